// File: rtl/pbit_sweep_collector_if.sv
// pbit_sweep_collector_if: valid/ready sample port carrying captured p-bit state vectors
interface pbit_sweep_collector_if #(parameter int W = 5);
  logic         valid;
  logic         ready;
  logic [W-1:0] data;
  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pbit_sweep_collector.sv
// pbit_sweep_collector: tracks in-order p-bit update sweeps and buffers one state sample per clean sweep
module pbit_sweep_collector #(
  parameter int N_PBITS = 5,
  parameter int DEPTH   = 4,
  parameter int BURN_IN = 0,
  parameter int CNT_W   = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_PBITS-1:0]       update_in_i,
  input  logic [N_PBITS-1:0]       pbit_state_i,
  pbit_sweep_collector_if.master   smp,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic [CNT_W-1:0]         sweep_count_o,
  output logic                     seq_error_o,
  output logic                     overflow_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [CNT_W-1:0] BURN = CNT_W'(BURN_IN);
  logic [N_PBITS-1:0] exp_q, exp_d;
  logic               pend_q, pend_d, part_q, part_d, serr_q, serr_d, ovf_q, ovf_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [LW-1:0]      wp_q, wp_d, rp_q, rp_d;
  logic [N_PBITS-1:0] mem [DEPTH];
  logic               idle, hit, onehot, push, pop, full, wr;
  always_comb begin
    idle   = update_in_i == '0;
    hit    = update_in_i == exp_q;
    onehot = !idle && ((update_in_i & (update_in_i - N_PBITS'(1))) == '0);
    exp_d  = idle ? exp_q
           : hit ? {exp_q[N_PBITS-2:0], exp_q[N_PBITS-1]}
           : onehot ? {update_in_i[N_PBITS-2:0], update_in_i[N_PBITS-1]}
           : N_PBITS'(1);
    part_d = idle ? part_q : hit ? part_q && !exp_q[0] : 1'b1;
    pend_d = hit && exp_q[N_PBITS-1] && !part_q;
    serr_d = serr_q || (!idle && !hit);
    push   = pend_q && cnt_q >= BURN;
    cnt_d  = cnt_q + CNT_W'(pend_q && cnt_q != '1);
    full   = level_o == LW'(DEPTH);
    pop    = smp.valid && smp.ready;
    wr     = push && (!full || pop);
    ovf_d  = ovf_q || (push && !wr);
    wp_d   = wp_q + LW'(wr);
    rp_d   = rp_q + LW'(pop);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      exp_q  <= N_PBITS'(1);
      pend_q <= 1'b0;
      part_q <= 1'b0;
      serr_q <= 1'b0;
      ovf_q  <= 1'b0;
      cnt_q  <= '0;
      wp_q   <= '0;
      rp_q   <= '0;
    end else begin
      exp_q  <= exp_d;
      pend_q <= pend_d;
      part_q <= part_d;
      serr_q <= serr_d;
      ovf_q  <= ovf_d;
      cnt_q  <= cnt_d;
      wp_q   <= wp_d;
      rp_q   <= rp_d;
    end
  end
  // storage needs no reset: pointers define what is valid
  always_ff @(posedge clk) begin
    if (wr) mem[wp_q[AW-1:0]] <= pbit_state_i;
  end
  assign level_o       = wp_q - rp_q;
  assign smp.valid     = level_o != '0;
  assign smp.data      = smp.valid ? mem[rp_q[AW-1:0]] : '0;
  assign sweep_count_o = cnt_q;
  assign seq_error_o   = serr_q;
  assign overflow_o    = ovf_q;
endmodule

// File: doc/pbit_sweep_collector.md
# pbit_sweep_collector

Consumer-side counterpart to the p-bit update sequencer. It watches the one-hot update vector driven to the p-bit array and tracks sweep progress. At the end of each complete, in-order sweep it captures the array's state vector as one sample, buffers samples in a small FIFO, and presents them on a valid/ready port to downstream readout or accumulation logic. It also flags sequencing faults and buffer overflow.

## Interface
- N_PBITS, 5, number of p-bits; width of update and state vectors (≥2)
- DEPTH, 4, sample FIFO depth (power of 2, ≥2)
- BURN_IN, 0, number of initial clean sweeps counted but not pushed
- CNT_W, 16, width of sweep counter
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high; clears all state immediately
- update_in  input  N_PBITS  update enables seen by the p-bit array (one-hot or zero)
- pbit_state  input  N_PBITS  current p-bit outputs; a p-bit's new value is visible the cycle after its update pulse
- sample_ready  input  1  downstream accepts the head sample
- sample_valid  output  1  FIFO non-empty
- sample_data  output  N_PBITS  head sample (first-word-fall-through); 0 when empty
- level  output  log2(DEPTH)+1  FIFO occupancy
- sweep_count  output  CNT_W  completed clean sweeps, saturating at all-ones
- seq_error  output  1  sticky: illegal or out-of-order update seen
- overflow  output  1  sticky: sample dropped because FIFO full

## Operation
- Internal state:
  - expect: one-hot, reset to bit 0
  - pend: capture pending, reset 0
  - partial: current sweep invalid, reset 0
  - FIFO read/write pointers and storage
- Per edge, evaluated on update_in:
  - All-zero: idle. expect and partial are unchanged.
  - Equal to expect: accept the pulse and rotate expect left (bit N-1 wraps to bit 0). Accepting bit 0 clears partial. Accepting bit N-1 with partial=0 sets pend. Accepting bit N-1 with partial=1 discards the sweep (no pend).
  - One-hot but not equal to expect: set seq_error, set expect = rotate-left(update_in), and set partial=1.
  - Not one-hot (≥2 bits): set seq_error, set expect = bit 0, and set partial=1.
- Capture: on the edge where pend=1, clear pend and process pbit_state.
  - If sweep_count ≥ BURN_IN, push pbit_state into the FIFO.
  - sweep_count increments, saturating, whether or not the sample is pushed.
  - pend can be set again on the same edge; a legal sequencer makes this impossible for N_PBITS ≥ 2.
- FIFO:
  - Pop occurs when sample_valid && sample_ready.
  - A push when level=DEPTH is accepted only if a pop happens on the same edge. Otherwise the new sample is dropped, overflow is set, and existing contents are unchanged.
  - A simultaneous push and pop at non-full level leaves level unchanged.
  - A pop when empty is ignored.
- seq_error and overflow stay set until reset.

## Timing
- Reset (asynchronous, effective without a clock edge) drives:
  - sample_valid=0, sample_data=0, level=0
  - sweep_count=0, seq_error=0, overflow=0
  - expect=bit 0, pend=0, partial=0
- FIFO contents are discarded on reset.
- Reset mid-sweep abandons the sweep. The next bit-0 pulse starts a fresh sweep.
- Latency:
  - Edge E accepts bit N-1. Edge E+1 captures pbit_state from the cycle between E and E+1.
  - sample_valid, level and sweep_count update after E+1.
  - Into an empty FIFO: sample_data is valid in the cycle after E+1.
- Free-running sequencer: one sample every N_PBITS cycles. The FIFO sustains this with sample_ready tied high.
- Gaps (update_in=0) anywhere in a sweep are legal and only stretch it.
- seq_error is set after the edge where the bad vector is sampled.

## Test plan
- Reset, N_PBITS=5, free-running rotation 00001→10000 repeating, pbit_state held at 10110, sample_ready=1 → sample_valid high one cycle in every 5 with data 10110; sweep_count reads 1, 2, 3 after the 1st–3rd sweeps; seq_error=0.
- BURN_IN=2, three clean sweeps → no sample_valid for sweeps 1–2, one sample after sweep 3, sweep_count=3.
- sample_ready=0, six sweeps with pbit_state=1,2,3,4,5,6 at the capture points, DEPTH=4 → level=4 and overflow=1 after the 5th sweep; raising sample_ready drains 1,2,3,4 in order, then sample_valid=0 and sample_data=0.
- Update pattern 00001, 00010, 01000 (skip), 10000 → seq_error=1 after the 01000 edge; sweep discarded with no sample. A following full sweep 00001…10000 yields exactly one sample. Separately, update_in=00011 → seq_error=1 and expect realigns to bit 0.
- Sweep with zero gaps between pulses (e.g. 00001, 0, 0, 00010, 0, 00100, …) → exactly one sample, captured the cycle after the 10000 edge.
- Assert reset asynchronously mid-sweep with level=2, overflow=1 → all outputs 0 immediately; the next complete sweep produces a sample with sweep_count=1.
